// File: rtl/glyph_pkg.sv
// Shared constants and types for the glyph system RAM port-A arbiter.
package glyph_pkg;

  localparam int unsigned SYS_DATA_WIDTH = 16;
  localparam int unsigned SYS_ADDR_WIDTH = 16;
  localparam int unsigned RD_LATENCY     = 2;

  typedef enum logic {
    REQ_MOVE = 1'b0,
    REQ_HOST = 1'b1
  } req_idx_e;

  // One stage of the read-return pipeline.
  typedef struct packed {
    logic     rd;
    req_idx_e tag;
  } rd_tag_t;

endpackage

// File: rtl/glyph_port_arbiter_if.sv
// Requester handshake and RAM port-A bus of the glyph port-A arbiter.
interface glyph_port_arbiter_if import glyph_pkg::*; #(
  parameter int unsigned DATA_WIDTH = SYS_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = SYS_ADDR_WIDTH
);
  logic                  req0, req1;
  logic                  we0, we1;
  logic [ADDR_WIDTH-1:0] addr0, addr1;
  logic [DATA_WIDTH-1:0] wdata0, wdata1;
  logic                  gnt0, gnt1;
  logic                  rvalid0, rvalid1;
  logic [DATA_WIDTH-1:0] rdata;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [DATA_WIDTH-1:0] data_a;
  logic                  we_a;
  logic [DATA_WIDTH-1:0] q_a;

  // Requesters plus the RAM side.
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, q_a,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, addr_a, data_a, we_a
  );

  // The arbiter.
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, q_a,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, addr_a, data_a, we_a
  );
endinterface

// File: rtl/glyph_rr_arb2.sv
// Pure two-way round-robin pick: grants the sole eligible requester, or the one not served last.
module glyph_rr_arb2 import glyph_pkg::*; (
  input  logic [1:0] elig_i,
  input  req_idx_e   last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    unique case (elig_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_i == REQ_HOST) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/glyph_port_arbiter.sv
// Round-robin arbiter serialising two requesters onto glyph RAM port A.
// Optional GLYPH_ARB_VBLANK_GATE_EN: writes are only eligible while vblank is high.
module glyph_port_arbiter import glyph_pkg::*; #(
  parameter int unsigned DATA_WIDTH = SYS_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = SYS_ADDR_WIDTH
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 vblank,
  glyph_port_arbiter_if.slave  bus
);

  logic [1:0]            elig;
  logic [1:0]            pick;
  logic                  accept;
  req_idx_e              win;

  req_idx_e              last_q, last_d;
  logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d;
  logic [DATA_WIDTH-1:0] data_a_q, data_a_d;
  logic                  we_a_q, we_a_d;
  rd_tag_t [RD_LATENCY-1:0] pipe_q, pipe_d;

`ifdef GLYPH_ARB_VBLANK_GATE_EN
  assign elig[0] = bus.req0 & (~bus.we0 | vblank);
  assign elig[1] = bus.req1 & (~bus.we1 | vblank);
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign elig          = {bus.req1, bus.req0};
`endif

  glyph_rr_arb2 u_rr_arb2 (
    .elig_i (elig),
    .last_i (last_q),
    .gnt_o  (pick)
  );

  assign bus.gnt0 = pick[0] & resetn;
  assign bus.gnt1 = pick[1] & resetn;
  assign accept   = bus.gnt0 | bus.gnt1;
  assign win      = bus.gnt1 ? REQ_HOST : REQ_MOVE;

  always_comb begin
    last_d   = last_q;
    addr_a_d = addr_a_q;
    data_a_d = data_a_q;
    we_a_d   = 1'b0;
    pipe_d   = {pipe_q[RD_LATENCY-2:0], rd_tag_t'{rd: 1'b0, tag: REQ_MOVE}};
    if (accept) begin
      last_d   = win;
      addr_a_d = (win == REQ_HOST) ? bus.addr1  : bus.addr0;
      data_a_d = (win == REQ_HOST) ? bus.wdata1 : bus.wdata0;
      we_a_d   = (win == REQ_HOST) ? bus.we1    : bus.we0;
      pipe_d[0] = rd_tag_t'{rd: ~we_a_d, tag: win};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_q   <= REQ_HOST;
      addr_a_q <= '0;
      data_a_q <= '0;
      we_a_q   <= 1'b0;
      pipe_q   <= '0;
    end else begin
      last_q   <= last_d;
      addr_a_q <= addr_a_d;
      data_a_q <= data_a_d;
      we_a_q   <= we_a_d;
      pipe_q   <= pipe_d;
    end
  end

  assign bus.addr_a  = addr_a_q;
  assign bus.data_a  = data_a_q;
  assign bus.we_a    = we_a_q;
  // The oldest stage lines up with the cycle the RAM presents q_a.
  assign bus.rvalid0 = pipe_q[RD_LATENCY-1].rd & (pipe_q[RD_LATENCY-1].tag == REQ_MOVE);
  assign bus.rvalid1 = pipe_q[RD_LATENCY-1].rd & (pipe_q[RD_LATENCY-1].tag == REQ_HOST);
  assign bus.rdata   = bus.q_a;

endmodule

// File: tb/tb_glyph_port_arbiter.sv
// Self-checking bench for glyph_port_arbiter: RAM model, transaction-level reference model,
// per-cycle comparison on the falling edge, plus directed literal expectations.
module tb_glyph_port_arbiter;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic vblank = 1'b0;

  glyph_port_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) bus ();

  glyph_port_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) dut (
    .clk    (clk),
    .resetn (resetn),
    .vblank (vblank),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // RAM port A: write-first, one-cycle read latency.
  logic [15:0] ram [0:65535];
  always @(posedge clk) begin
    bus.q_a <= bus.we_a ? bus.data_a : ram[bus.addr_a];
    if (bus.we_a) ram[bus.addr_a] = bus.data_a;
  end

  // Reference model state.
  logic [15:0] m_mem [0:65535];
  int          m_last = 1;
  logic [15:0] m_addr = '0, m_data = '0;
  bit          pv [4];
  logic        pwe [4];
  logic [15:0] paddr [4], pdata [4];
  bit          rv [4];
  int          rtag [4];
  logic [15:0] rdat [4];
  int          cyc = 0;

  int          rv_log[$];
  logic [15:0] rlog0[$], rlog1[$];
  int          wecnt = 0;

  function automatic bit m_elig(bit req, bit we);
`ifdef GLYPH_ARB_VBLANK_GATE_EN
    return req && (!we || vblank);
`else
    return req && (we || !we);
`endif
  endfunction

  always @(negedge clk) begin
    int s, w;
    bit e0, e1;
    s = cyc % 4;
    if (!resetn) begin
      check("rst_gnt0", bus.gnt0, 0);
      check("rst_gnt1", bus.gnt1, 0);
      check("rst_we_a", bus.we_a, 0);
      check("rst_addr_a", bus.addr_a, 0);
      check("rst_data_a", bus.data_a, 0);
      check("rst_rvalid0", bus.rvalid0, 0);
      check("rst_rvalid1", bus.rvalid1, 0);
      for (int i = 0; i < 4; i++) begin pv[i] = 0; rv[i] = 0; end
      m_last = 1; m_addr = '0; m_data = '0;
    end else begin
      e0 = m_elig(bus.req0, bus.we0);
      e1 = m_elig(bus.req1, bus.we1);
      w = -1;
      if (e0 && e1) w = (m_last == 1) ? 0 : 1;
      else if (e0) w = 0;
      else if (e1) w = 1;
      check("gnt0", bus.gnt0, (w == 0));
      check("gnt1", bus.gnt1, (w == 1));
      if (pv[s]) begin
        m_addr = paddr[s];
        m_data = pdata[s];
        check("we_a", bus.we_a, pwe[s]);
      end else begin
        check("we_a_idle", bus.we_a, 0);
      end
      check("addr_a", bus.addr_a, m_addr);
      check("data_a", bus.data_a, m_data);
      check("rvalid0", bus.rvalid0, rv[s] && rtag[s] == 0);
      check("rvalid1", bus.rvalid1, rv[s] && rtag[s] == 1);
      if (rv[s]) check("rdata", bus.rdata, rdat[s]);
      if (bus.rvalid0) begin rlog0.push_back(bus.rdata); rv_log.push_back(0); end
      if (bus.rvalid1) begin rlog1.push_back(bus.rdata); rv_log.push_back(1); end
      if (bus.we_a) wecnt++;
      pv[s] = 0;
      rv[s] = 0;
      if (w >= 0) begin
        txn_t t;
        t.we    = (w == 0) ? bus.we0 : bus.we1;
        t.addr  = (w == 0) ? bus.addr0 : bus.addr1;
        t.wdata = (w == 0) ? bus.wdata0 : bus.wdata1;
        m_last = w;
        pv[(cyc + 1) % 4] = 1;
        pwe[(cyc + 1) % 4] = t.we;
        paddr[(cyc + 1) % 4] = t.addr;
        pdata[(cyc + 1) % 4] = t.wdata;
        if (t.we) m_mem[t.addr] = t.wdata;
        else begin
          rv[(cyc + 2) % 4] = 1;
          rtag[(cyc + 2) % 4] = w;
          rdat[(cyc + 2) % 4] = m_mem[t.addr];
        end
      end
    end
    cyc++;
  end

  // Requester driver.
  txn_t q0[$], q1[$];
  int   grant_log[$];
  int   first_gnt;

  task automatic present();
    bus.req0 = (q0.size() != 0);
    bus.req1 = (q1.size() != 0);
    bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
    if (q0.size() != 0) begin bus.we0 = q0[0].we; bus.addr0 = q0[0].addr; bus.wdata0 = q0[0].wdata; end
    if (q1.size() != 0) begin bus.we1 = q1[0].we; bus.addr1 = q1[0].addr; bus.wdata1 = q1[0].wdata; end
  endtask

  task automatic run_queues(int max_cyc);
    bit g0, g1;
    first_gnt = -1;
    for (int c = 0; c < max_cyc && (q0.size() != 0 || q1.size() != 0); c++) begin
      present();
      @(negedge clk);
      g0 = bus.gnt0;
      g1 = bus.gnt1;
      @(posedge clk);
      #1;
      if (g0 && q0.size() != 0) begin void'(q0.pop_front()); grant_log.push_back(0); end
      if (g1 && q1.size() != 0) begin void'(q1.pop_front()); grant_log.push_back(1); end
      if ((g0 || g1) && first_gnt < 0) first_gnt = c;
    end
    present();
  endtask

  task automatic push(int r, logic we, logic [15:0] addr, logic [15:0] wdata);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wdata;
    if (r == 0) q0.push_back(t);
    else q1.push_back(t);
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 65536; i++) begin ram[i] = '0; m_mem[i] = '0; end
    ram[16'h0123] = 16'hBEEF; m_mem[16'h0123] = 16'hBEEF;
    for (int i = 0; i < 4; i++) begin
      ram[16'h0100 + i] = 16'hA000 + 16'(i); m_mem[16'h0100 + i] = 16'hA000 + 16'(i);
      ram[16'h0200 + i] = 16'hB000 + 16'(i); m_mem[16'h0200 + i] = 16'hB000 + 16'(i);
    end
    present();

    // Reset with a pending read, then the single read.
    push(0, 0, 16'h0123, 16'h0000);
    present();
    @(negedge clk);
    check("lit_rst_gnt0", bus.gnt0, 0);
    check("lit_rst_we_a", bus.we_a, 0);
    check("lit_rst_addr_a", bus.addr_a, 0);
    @(posedge clk); #1;
    resetn = 1;
    run_queues(5);
    check("lit_first_gnt_cycle", first_gnt, 0);
    check("lit_single_done", q0.size(), 0);
    settle();
    check("lit_single_rv0_cnt", rlog0.size(), 1);
    check("lit_single_rdata", rlog0[0], 16'hBEEF);
    check("lit_single_rv1_cnt", rlog1.size(), 0);

    // Write by host, read of the same address by the movement engine on the next cycle.
    wecnt = 0;
    push(1, 1, 16'h0040, 16'h5A5A);
    run_queues(5);
    push(0, 0, 16'h0040, 16'h0000);
    run_queues(5);
    check("lit_wr_rd_done", q0.size() + q1.size(), 0);
    settle();
    check("lit_we_a_cycles", wecnt, 1);
    check("lit_raw_rdata", rlog0[rlog0.size() - 1], 16'h5A5A);

    // Write request outside vblank competing with a read.
    vblank = 0;
    grant_log.delete();
    push(1, 1, 16'h0050, 16'h1234);
    push(0, 0, 16'h0040, 16'h0000);
    run_queues(3);
`ifdef GLYPH_ARB_VBLANK_GATE_EN
    check("lit_vb_write_held", q1.size(), 1);
    check("lit_vb_read_done", q0.size(), 0);
    check("lit_vb_only_gnt0", grant_log.size() == 1 && grant_log[0] == 0, 1);
    vblank = 1;
    run_queues(4);
    check("lit_vb_gnt1_same_cycle", first_gnt, 0);
`else
    check("lit_vb_ignored", q0.size() + q1.size(), 0);
    check("lit_vb_two_grants", grant_log.size(), 2);
`endif
    check("lit_vb_all_done", q0.size() + q1.size(), 0);
    settle();
    check("lit_vb_rdata", rlog0[rlog0.size() - 1], 16'h5A5A);
    vblank = 0;

    // Reset asserted the cycle after a read accept: its rvalid must never appear.
    n = rlog0.size();
    push(0, 0, 16'h0123, 16'h0000);
    run_queues(5);
    resetn = 0;
    settle();
    check("lit_midrst_no_rvalid", rlog0.size(), n);
    resetn = 1;

    // Contention from reset: four reads each, alternating from requester 0.
    grant_log.delete();
    rv_log.delete();
    for (int i = 0; i < 4; i++) begin
      push(0, 0, 16'h0100 + 16'(i), 16'h0000);
      push(1, 0, 16'h0200 + 16'(i), 16'h0000);
    end
    run_queues(20);
    check("lit_cont_done", q0.size() + q1.size(), 0);
    settle();
    check("lit_cont_gnt_cnt", grant_log.size(), 8);
    check("lit_cont_rv_cnt", rv_log.size(), 8);
    for (int i = 0; i < 8 && i < grant_log.size() && i < rv_log.size(); i++) begin
      check($sformatf("lit_cont_gnt_%0d", i), grant_log[i], i % 2);
      check($sformatf("lit_cont_rv_%0d", i), rv_log[i], i % 2);
    end
    check("lit_cont_rdata0", rlog0[rlog0.size() - 1], 16'hA003);
    check("lit_cont_rdata1", rlog1[rlog1.size() - 1], 16'hB003);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
